// File: rtl/bbox_detect.sv
// Foreground pixel count and bounding-box extraction over one video frame.
// Results are latched once per frame and held until the next completed frame.
module bbox_detect #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int PIX_DELAY = 1,
  parameter int MIN_COUNT = 64
) (
  input  logic        PCLK,
  input  logic        RST,
  input  logic [11:0] VtcHCnt,
  input  logic [11:0] VtcVCnt,
  input  logic        pix_i,
  output logic        frame_done,
  output logic        box_valid,
  output logic [11:0] box_xmin,
  output logic [11:0] box_xmax,
  output logic [11:0] box_ymin,
  output logic [11:0] box_ymax,
  output logic [18:0] pix_count
);

  typedef enum logic [1:0] {IDLE, ACCUM, LATCH} state_t;

  localparam logic [18:0] CNT_MAX = '1;

  function automatic logic [18:0] sat_inc(input logic [18:0] c);
    return (c == CNT_MAX) ? c : c + 19'd1;
  endfunction

  function automatic logic [11:0] umin(input logic [11:0] a, input logic [11:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [11:0] umax(input logic [11:0] a, input logic [11:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t state_q, state_d;

  logic [18:0] cnt_q, cnt_d;
  logic [11:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [11:0] ymin_q, ymin_d, ymax_q, ymax_d;

  logic        done_q, done_d;
  logic        valid_q, valid_d;
  logic [18:0] count_q, count_d;
  logic [11:0] bxmin_q, bxmin_d, bxmax_q, bxmax_d;
  logic [11:0] bymin_q, bymin_d, bymax_q, bymax_d;

  logic [11:0] x;
  logic        pix_vld, hit, fs, fe;

  // The pixel arriving now belongs to a counter value PIX_DELAY cycles older.
  assign x       = VtcHCnt - 12'(PIX_DELAY);
  assign pix_vld = (VtcHCnt >= 12'(PIX_DELAY)) && (x < 12'(H_ACTIVE)) &&
                   (VtcVCnt < 12'(V_ACTIVE));
  assign hit     = pix_vld && pix_i;
  assign fs      = (VtcVCnt == 12'd0) && (VtcHCnt == 12'd0);
  assign fe      = (VtcVCnt == 12'(V_ACTIVE)) && (VtcHCnt == 12'd0);

  always_comb begin
    state_d = state_q;
    if (fs) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ACCUM:   state_d = fe ? LATCH : ACCUM;
        LATCH:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame start reseeds the accumulators so the FS-cycle pixel folds into fresh values.
  always_comb begin
    cnt_d  = fs ? 19'd0   : cnt_q;
    xmin_d = fs ? 12'hFFF : xmin_q;
    xmax_d = fs ? 12'd0   : xmax_q;
    ymin_d = fs ? 12'hFFF : ymin_q;
    ymax_d = fs ? 12'd0   : ymax_q;
    if (hit && (fs || state_q == ACCUM)) begin
      cnt_d  = sat_inc(cnt_d);
      xmin_d = umin(xmin_d, x);
      xmax_d = umax(xmax_d, x);
      ymin_d = umin(ymin_d, VtcVCnt);
      ymax_d = umax(ymax_d, VtcVCnt);
    end
  end

  always_comb begin
    done_d  = 1'b0;
    valid_d = valid_q;
    count_d = count_q;
    bxmin_d = bxmin_q;
    bxmax_d = bxmax_q;
    bymin_d = bymin_q;
    bymax_d = bymax_q;
    if (state_q == LATCH) begin
      done_d  = 1'b1;
      count_d = cnt_q;
      if (cnt_q >= 19'(MIN_COUNT)) begin
        valid_d = 1'b1;
        bxmin_d = xmin_q;
        bxmax_d = xmax_q;
        bymin_d = ymin_q;
        bymax_d = ymax_q;
      end else begin
        valid_d = 1'b0;
        bxmin_d = 12'd0;
        bxmax_d = 12'd0;
        bymin_d = 12'd0;
        bymax_d = 12'd0;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 19'd0;
      xmin_q  <= 12'hFFF;
      xmax_q  <= 12'd0;
      ymin_q  <= 12'hFFF;
      ymax_q  <= 12'd0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      count_q <= 19'd0;
      bxmin_q <= 12'd0;
      bxmax_q <= 12'd0;
      bymin_q <= 12'd0;
      bymax_q <= 12'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      count_q <= count_d;
      bxmin_q <= bxmin_d;
      bxmax_q <= bxmax_d;
      bymin_q <= bymin_d;
      bymax_q <= bymax_d;
    end
  end

  assign frame_done = done_q;
  assign box_valid  = valid_q;
  assign pix_count  = count_q;
  assign box_xmin   = bxmin_q;
  assign box_xmax   = bxmax_q;
  assign box_ymin   = bymin_q;
  assign box_ymax   = bymax_q;

endmodule
